// File: rtl/shift_link_pkg.sv
// Shared definitions for the universal shift-register serial link:
// receiver mode codes, frame direction codes and the transmitter FSM states.
package shift_link_pkg;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SHIFT,
    DONE
  } state_t;

  // Receiver mode used while bits are streaming; S_LOAD is never produced.
  function automatic logic [1:0] shift_mode(input logic dir);
    return (dir == DIR_LEFT) ? S_LEFT : S_RIGHT;
  endfunction

endpackage

// File: rtl/shift_link_tx_if.sv
// Bundle of the parallel request side and the serial receiver-facing side
// of the shift-link transmitter.
interface shift_link_tx_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] PData;
  logic             load;
  logic             dir;
  logic             ready;
  logic [1:0]       S;
  logic             SO;
  logic             rx_clear;
  logic             done;

  // master: data source / board side; slave: the transmitter itself
  modport master (
    output PData, load, dir,
    input  ready, S, SO, rx_clear, done
  );

  modport slave (
    input  PData, load, dir,
    output ready, S, SO, rx_clear, done
  );

endinterface

// File: rtl/shift_link_tx.sv
// Serial transmitter: clears the downstream universal shift register, streams
// a latched word into it LSB- or MSB-first, then pulses done. All outputs are flops.
module shift_link_tx
  import shift_link_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           clear,
  shift_link_tx_if.slave link
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   LSB_MASK = WIDTH'(1);
  localparam logic [WIDTH-1:0]   MSB_MASK = LSB_MASK << (WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             dir_q, dir_d;

  logic             ready_q, ready_d;
  logic [1:0]       s_q, s_d;
  logic             so_q, so_d;
  logic             rx_clear_q, rx_clear_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] lsb_view;
  logic [WIDTH-1:0] msb_view;

  // ready_q is high exactly in IDLE, so it doubles as the accept qualifier
  assign accept = link.load && ready_q;

  // State register. clear wins over everything, including a simultaneous load.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      dir_q      <= DIR_RIGHT;
      ready_q    <= 1'b1;
      s_q        <= S_HOLD;
      so_q       <= 1'b0;
      rx_clear_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      dir_q      <= dir_d;
      ready_q    <= ready_d;
      s_q        <= s_d;
      so_q       <= so_d;
      rx_clear_q <= rx_clear_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: sequencing, bit counter and the shadow copy of the word.
  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dir_d    = dir_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d = link.PData;
          dir_d    = link.dir;
          state_d  = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: decoded from the upcoming state so the outputs can be
  // registered without adding a cycle of latency to the frame.
  always_comb begin
    ready_d    = 1'b0;
    s_d        = S_HOLD;
    so_d       = 1'b0;
    rx_clear_d = 1'b0;
    done_d     = 1'b0;
    lsb_view   = shadow_d >> cnt_d;
    msb_view   = shadow_d << cnt_d;

    unique case (state_d)
      IDLE:  ready_d    = 1'b1;
      CLR:   rx_clear_d = 1'b1;
      SHIFT: begin
        s_d  = shift_mode(dir_d);
        // Right frames walk up from bit 0, left frames walk down from the MSB.
        so_d = (dir_d == DIR_LEFT) ? |(msb_view & MSB_MASK)
                                   : |(lsb_view & LSB_MASK);
      end
      DONE:  done_d     = 1'b1;
      default: ready_d  = 1'b0;
    endcase
  end

  assign link.ready    = ready_q;
  assign link.S        = s_q;
  assign link.SO       = so_q;
  assign link.rx_clear = rx_clear_q;
  assign link.done     = done_q;

endmodule

// File: tb/tb_shift_link_tx.sv
// Bench for shift_link_tx: drives frames into the transmitter, feeds a
// behavioural universal shift register, and compares each cycle to a frame timeline.
module tb_shift_link_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic [W-1:0] rx_q;
  int           n_vec = 0;
  int           n_err = 0;

  shift_link_tx_if #(.WIDTH(W)) link ();

  shift_link_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .link  (link.slave)
  );

  always #5 clk = ~clk;

  // Behavioural receiver: clear, hold, shift right (SR in at MSB), shift left (SL in at LSB)
  always @(posedge clk) begin
    if (link.rx_clear) rx_q <= '0;
    else begin
      case (link.S)
        2'b01:   rx_q <= {link.SO, rx_q[W-1:1]};
        2'b10:   rx_q <= {rx_q[W-2:0], link.SO};
        default: rx_q <= rx_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs for cycle c after the accept edge (c = 1 .. W+3)
  task automatic check_cycle(input int f, input int c, input logic [W-1:0] word, input logic d);
    logic [1:0]   e_s     = 2'b00;
    logic         e_so    = 1'b0;
    logic         e_ready = 1'b0;
    logic         e_rx    = 1'b0;
    logic         e_done  = 1'b0;
    logic [W-1:0] tmp;
    if (c == 1) e_rx = 1'b1;
    else if (c <= W + 1) begin
      e_s  = d ? 2'b10 : 2'b01;
      tmp  = d ? (word >> (W - 1 - (c - 2))) : (word >> (c - 2));
      e_so = tmp[0];
    end else if (c == W + 2) e_done = 1'b1;
    else e_ready = 1'b1;
    check($sformatf("f%0d c%0d ready", f, c),    32'(link.ready),    32'(e_ready));
    check($sformatf("f%0d c%0d S", f, c),        32'(link.S),        32'(e_s));
    check($sformatf("f%0d c%0d SO", f, c),       32'(link.SO),       32'(e_so));
    check($sformatf("f%0d c%0d rx_clear", f, c), 32'(link.rx_clear), 32'(e_rx));
    check($sformatf("f%0d c%0d done", f, c),     32'(link.done),     32'(e_done));
    if (c == W + 2) check($sformatf("f%0d rx_q", f), 32'(rx_q), 32'(word));
  endtask

  // Entered at a negedge. Accepts one frame, scrambles PData/dir while busy,
  // optionally holds load high, optionally clears at cycle abort_c.
  task automatic run_frame(input int f, input logic [W-1:0] word, input logic d,
                           input logic hold, input int abort_c);
    int guard = 0;
    while (!link.ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("f%0d ready before accept", f), 32'(link.ready), 32'd1);
    link.PData = word;
    link.dir   = d;
    link.load  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= W + 3; c++) begin
      #1;
      link.load  = hold && (abort_c == 0);
      link.PData = W'($urandom);
      link.dir   = 1'($urandom);
      @(negedge clk);
      check_cycle(f, c, word, d);
      if (c == abort_c) begin
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("f%0d abort+%0d ready", f, k),    32'(link.ready),    32'd1);
          check($sformatf("f%0d abort+%0d S", f, k),        32'(link.S),        32'd0);
          check($sformatf("f%0d abort+%0d SO", f, k),       32'(link.SO),       32'd0);
          check($sformatf("f%0d abort+%0d done", f, k),     32'(link.done),     32'd0);
          check($sformatf("f%0d abort+%0d rx_clear", f, k), 32'(link.rx_clear), 32'd0);
        end
        return;
      end
      if (c < W + 3) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    link.load = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle ready", 32'(link.ready), 32'd1);
      check("idle S",     32'(link.S),     32'd0);
      check("idle done",  32'(link.done),  32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear      = 1'b1;
    link.load  = 1'b0;
    link.PData = '0;
    link.dir   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready",    32'(link.ready),    32'd1);
    check("reset S",        32'(link.S),        32'd0);
    check("reset SO",       32'(link.SO),       32'd0);
    check("reset done",     32'(link.done),     32'd0);
    check("reset rx_clear", 32'(link.rx_clear), 32'd0);
    clear = 1'b0;
    @(negedge clk);

    run_frame(1, 4'b1011, 1'b0, 1'b0, 0);
    run_frame(2, 4'b1011, 1'b1, 1'b0, 0);
    idle(2);
    run_frame(3, 4'b0110, 1'b0, 1'b1, 0);
    run_frame(4, 4'b1001, 1'b0, 1'b0, 0);
    run_frame(5, 4'b1110, 1'b0, 1'b0, 4);
    run_frame(6, 4'b0101, 1'b0, 1'b0, 0);

    // clear and load on the same edge from IDLE: nothing accepted
    @(negedge clk);
    clear      = 1'b1;
    link.load  = 1'b1;
    link.PData = 4'b1100;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    link.load = 1'b0;
    @(negedge clk);
    check("simul rx_clear", 32'(link.rx_clear), 32'd0);
    check("simul ready",    32'(link.ready),    32'd1);
    @(negedge clk);
    check("simul rx_clear+1", 32'(link.rx_clear), 32'd0);

    for (int f = 10; f < 40; f++) begin
      logic [W-1:0] w;
      logic         d;
      logic         h;
      int           ab;
      w  = W'($urandom);
      d  = 1'($urandom);
      h  = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W + 2)) : 0;
      run_frame(f, w, d, h, ab);
      if (!h && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_link_tx.md
# shift_link_tx

Serial transmitter for the 4-bit universal shift-register link. It accepts a parallel word, then drives serial data and the mode-select pair into a downstream universal shift register (S = 00 hold, 01 shift right, 10 shift left, 11 load; synchronous clear). After one frame, the receiver's Q equals the transmitted word. It sits between the parallel data source and the shift-register receiver on the board.

## Interface
- WIDTH, 4: word width; equals receiver register width; minimum 2.
- clk  in  1  system clock; all state updates on rising edge.
- clear  in  1  reset, synchronous and active-high.
- PData  in  WIDTH  word to send; sampled only on accept.
- load  in  1  request; accepted on a rising edge where load=1 and ready=1.
- dir  in  1  sampled on accept; 0 = right-shift frame, 1 = left-shift frame.
- ready  out  1  high in IDLE only.
- S  out  2  mode select for receiver.
- SO  out  1  serial bit; drives receiver SR (dir=0) or SL (dir=1).
- rx_clear  out  1  receiver clear pulse.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- All outputs registered. FSM states: IDLE, CLR, SHIFT, DONE.
- Reset values: ready=1, S=00, SO=0, rx_clear=0, done=0, state=IDLE, bit counter=0, shadow word=0.
- IDLE: ready=1, S=00. On accept: latch PData into shadow, latch dir, go to CLR.
- CLR: one cycle; rx_clear=1, S=00, ready=0. Go to SHIFT with counter=0.
- SHIFT: WIDTH cycles; S=01 (dir=0) or 10 (dir=1).
  - dir=0 sends shadow LSB first, bit k on cycle k.
  - dir=1 sends MSB first, bit WIDTH-1-k on cycle k.
  - Counter width $clog2(WIDTH+1). Leave SHIFT when counter reaches WIDTH-1.
- DONE: one cycle; done=1, S=00, SO=0. Then go to IDLE.
- load while ready=0 is ignored and not queued. PData/dir changes after accept have no effect on the frame in flight.
- S=11 is never driven.
- clear at any state (including mid-SHIFT) aborts the frame. All outputs take reset values at that edge; no done pulse. clear dominates a simultaneous load.

## Timing
- Accept at edge E0.
- Cycle after E0: rx_clear=1.
- Cycles E0+2 .. E0+WIDTH+1: SHIFT bits. The receiver samples each bit on the edge ending its cycle.
- Cycle E0+WIDTH+2: done=1. Receiver Q holds the full word from that cycle on.
- ready=1 again at E0+WIDTH+3. Back-to-back accept is possible on that edge.
- Frame period is WIDTH+3 cycles (7 for WIDTH=4).
- S and SO change only on rising edges and are glitch-free to the receiver.

## Structure
- Shared package shift_link_pkg holds:
  - mode constants S_HOLD=2'b00, S_RIGHT=2'b01, S_LEFT=2'b10, S_LOAD=2'b11;
  - the FSM state typedef (IDLE, CLR, SHIFT, DONE);
  - DIR_RIGHT=0, DIR_LEFT=1.
- Single module, no sub-modules. The counter and shadow register are inline.
- The bench connects the DUT to a behavioural universal shift-register receiver: clk shared, clear←rx_clear, S←S, SR/SL←SO.

## Test plan
- Reset: assert clear 2 cycles → ready=1, S=00, SO=0, done=0, rx_clear=0.
- Right frame: PData=4'b1011, dir=0, load 1 cycle → SO sequence 1,1,0,1 with S=01 for 4 cycles; done at accept+6; receiver Q=1011.
- Left frame: PData=4'b1011, dir=1 → SO 1,0,1,1 with S=10; receiver Q=1011; ready returns at accept+7.
- Busy ignore: load=1 held continuously with PData 0110 then 1001 changed mid-frame → first frame delivers 0110; second frame accepted exactly at accept+7 and delivers 1001.
- Abort: clear during third SHIFT cycle → next cycle S=00, ready=1, no done; a new 4'b0101 frame then completes correctly.
- Simultaneous: clear=1 and load=1 on the same edge from IDLE → no accept, rx_clear stays 0.
